// File: rtl/usb_uart_rx_pkg.sv
// Shared UART definitions: receiver states and bit-timing helper.
package usb_uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/usb_uart_rx_if.sv
// Serial line in, received byte and status strobes out.
interface usb_uart_rx_if;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    modport master (output rx, input  data_out, data_valid, frame_err, rx_busy);
    modport slave  (input  rx, output data_out, data_valid, frame_err, rx_busy);
endinterface

// File: rtl/usb_uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; resets to the idle line level.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_ff;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_ff <= {2{RST_VAL}};
        else            r_ff <= {r_ff[0], i_d};
    end

    assign o_q = r_ff[1];
endmodule

// File: rtl/usb_uart_rx.sv
// UART 8N1 receiver: mid-bit sampling FSM, LSB-first shift, one-cycle valid / framing-error strobes.
module usb_uart_rx
    import usb_uart_rx_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    usb_uart_rx_if.slave  u_if
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT - 1);

    rx_state_t     r_state, w_next;
    logic [CW-1:0] r_bit_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data_out;
    logic          r_data_valid, r_frame_err;
    logic          w_rx_s, w_cnt_clr, w_shift, w_load, w_ferr;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (u_if.rx),
        .o_q       (w_rx_s)
    );

    // Once START has confirmed the start bit at its midpoint, every later sample lands mid-bit.
    always_comb begin
        w_next    = r_state;
        w_cnt_clr = 1'b0;
        w_shift   = 1'b0;
        w_load    = 1'b0;
        w_ferr    = 1'b0;
        case (r_state)
            IDLE: if (!w_rx_s) begin
                w_next    = START;
                w_cnt_clr = 1'b1;
            end
            START: if (r_bit_cnt == HALF_CNT) begin
                w_cnt_clr = 1'b1;
                w_next    = w_rx_s ? IDLE : DATA;
            end
            DATA: if (r_bit_cnt == LAST_CNT) begin
                w_cnt_clr = 1'b1;
                w_shift   = 1'b1;
                if (r_idx == 3'd7) w_next = STOP;
            end
            STOP: if (r_bit_cnt == LAST_CNT) begin
                w_cnt_clr = 1'b1;
                if (w_rx_s) begin
                    w_load = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_ferr = 1'b1;
                    w_next = BREAK;
                end
            end
            BREAK: if (w_rx_s) begin
                w_cnt_clr = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_idx        <= '0;
            r_shreg      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_data_valid <= w_load;
            r_frame_err  <= w_ferr;
            if (w_cnt_clr || r_state == IDLE || r_state == BREAK) r_bit_cnt <= '0;
            else                                                  r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_state != DATA) r_idx <= '0;
            else if (w_shift)    r_idx <= r_idx + 1'b1;
            if (w_shift) r_shreg    <= {w_rx_s, r_shreg[7:1]};
            if (w_load)  r_data_out <= r_shreg;
        end
    end

    assign u_if.data_out   = r_data_out;
    assign u_if.data_valid = r_data_valid;
    assign u_if.frame_err  = r_frame_err;
    assign u_if.rx_busy    = (r_state != IDLE);
endmodule
